div_16_arbiter: RTL and testbench
=================================

Name: div_16_arbiter

Overview:
- Shares one div_16 divider (init_in/A/B/R/done interface) between NREQ requesters.
- Round-robin arbitration; latches the winner's operands, sequences the divider start pulse, waits for done and returns the quotient.
- Intercepts divide-by-zero without touching the divider.
- Runs a watchdog so a hung divider cannot lock the bus.
- Sits between the requesting datapath blocks and a single div_16 instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- INIT_CYCLES, 2, cycles div_init is held high per operation (1..4).
- TIMEOUT, 40, max cycles in WAIT before abort (must exceed divider latency of 17).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  level request per requester; hold until gnt.
- a_in  in  16*NREQ  dividend per requester, slice i = [16i+15:16i].
- b_in  in  16*NREQ  divisor per requester, same slicing.
- gnt  out  NREQ  one-cycle pulse: operands of that requester latched.
- rsp_valid  out  NREQ  one-cycle pulse: result for that requester on rsp_q.
- rsp_q  out  16  quotient (shared bus, valid only with rsp_valid).
- rsp_err  out  2  00 ok, 01 divide-by-zero, 10 timeout; valid with rsp_valid.
- busy  out  1  high whenever state != IDLE.
- div_init  out  1  to div_16 init_in.
- div_a  out  16  to div_16 A.
- div_b  out  16  to div_16 B.
- div_r  in  16  from div_16 R.
- div_done  in  1  from div_16 done.

Behaviour:
- Reset (async, rst=1): state=IDLE, rr_ptr=0, gnt=0, rsp_valid=0, rsp_q=0, rsp_err=0, busy=0, div_init=0, div_a=0, div_b=0, counters=0. Reset mid-operation aborts silently; no rsp_valid is issued for the aborted request.
- States: IDLE, START, WAIT, RESP.
- IDLE, req!=0:
  - Winner = first set bit scanning from rr_ptr upward, wrapping modulo NREQ.
  - Register sel, div_a=a_in[sel], div_b=b_in[sel].
  - Pulse gnt[sel] for the next cycle.
  - Next state: RESP with rsp_err=01 and rsp_q=16'hFFFF if b_in[sel]==0; otherwise START.
- START: div_init=1 for exactly INIT_CYCLES cycles (counter), then div_init=0, clear the watchdog and go to WAIT. div_done is ignored in START.
- WAIT: watchdog increments each cycle.
  - First cycle with div_done=1: rsp_q=div_r, rsp_err=00, go to RESP.
  - Watchdog reaches TIMEOUT first: rsp_q=16'hFFFF, rsp_err=10, go to RESP.
  - done and timeout in the same cycle: done wins.
- RESP: rsp_valid[sel]=1 for one cycle, rr_ptr = (sel+1) mod NREQ, then IDLE.
  - rsp_q and rsp_err hold until the next RESP.
- Latency: grant at cycle 0. Non-zero divisor: rsp_valid at 1 + INIT_CYCLES + divider latency + 1 cycles after grant. Zero divisor: rsp_valid on cycle 1 after grant.
- div_a and div_b stay stable from grant until leaving RESP.
- New requests are not sampled while busy. A requester may drop req after gnt and must not re-raise it before its rsp_valid.
- Simultaneous requests: resolved only by rr_ptr; no requester waits more than NREQ-1 grants.
- A requester dropping req before grant is simply not served; no error.
- Outputs gnt, rsp_valid, div_init are registered (no combinational path from req).

Test Plan:
- Single op: req[0]=1, a=16'h0052, b=16'h0009 → gnt[0] pulse, div_init high 2 cycles, rsp_valid[0] with rsp_q=16'h0009, rsp_err=00.
- Divide-by-zero: req[2], a=16'h1234, b=0 → gnt[2] then rsp_valid[2] next cycle, rsp_q=16'hFFFF, rsp_err=01, div_init never asserted.
- Round robin: req=4'b1111 held, each with distinct operands (e.g. 100/7, 255/5, 16/4, 9/3) → grant order 0,1,2,3,0; each rsp matches 14,51,4,3.
- Fairness: req[1] and req[3] held after a prior grant to 1 (rr_ptr=2) → next grant is 3, then 1.
- Timeout: divider model never asserts done → rsp_valid after TIMEOUT (40) WAIT cycles, rsp_err=10, rsp_q=16'hFFFF, arbiter returns to IDLE and serves the next request normally.
- Reset mid-WAIT: assert rst asynchronously → all outputs 0 immediately, busy=0, no rsp_valid; a subsequent request (e.g. 0x0052/0x0009) completes correctly with quotient 0x0009.

Source files
------------

// File: rtl/div_16_arbiter.sv
// Round-robin front end sharing one div_16 divider between NREQ requesters.
// Handles divide-by-zero locally and aborts a hung divider with a watchdog.
module div_16_arbiter #(
  parameter int NREQ        = 4,
  parameter int INIT_CYCLES = 2,
  parameter int TIMEOUT     = 40
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   a_in,
  input  logic [16*NREQ-1:0]   b_in,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [15:0]          rsp_q,
  output logic [1:0]           rsp_err,
  output logic                 busy,
  output logic                 div_init,
  output logic [15:0]          div_a,
  output logic [15:0]          div_b,
  input  logic [15:0]          div_r,
  input  logic                 div_done
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int IW = 3;
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t                 state;
  logic [PW-1:0]          rr_ptr, sel, win;
  logic [IW-1:0]          init_cnt;
  logic [WW-1:0]          wd;
  logic [NREQ-1:0][15:0]  a_arr, b_arr;
  int                     j;

  assign a_arr = a_in;
  assign b_arr = b_in;
  assign busy  = (state != IDLE);

  // Scan downward so the requester closest to rr_ptr is the last to overwrite win.
  always_comb begin
    win = '0;
    j   = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = int'(rr_ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (req[j]) win = PW'(j);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      sel       <= '0;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_q     <= '0;
      rsp_err   <= '0;
      div_init  <= 1'b0;
      div_a     <= '0;
      div_b     <= '0;
      init_cnt  <= '0;
      wd        <= '0;
    end else begin
      gnt       <= '0;
      rsp_valid <= '0;
      case (state)
        IDLE: if (|req) begin
          sel   <= win;
          div_a <= a_arr[win];
          div_b <= b_arr[win];
          gnt   <= ONE << win;
          if (b_arr[win] == 16'h0000) begin
            rsp_q   <= 16'hFFFF;
            rsp_err <= 2'b01;
            state   <= RESP;
          end else begin
            div_init <= 1'b1;
            init_cnt <= '0;
            state    <= START;
          end
        end
        START: begin
          if (init_cnt == IW'(INIT_CYCLES - 1)) begin
            div_init <= 1'b0;
            wd       <= '0;
            state    <= WAIT;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end
        WAIT: begin
          // done is checked first so it wins over a coincident timeout
          if (div_done) begin
            rsp_q   <= div_r;
            rsp_err <= 2'b00;
            state   <= RESP;
          end else if (wd == WW'(TIMEOUT - 1)) begin
            rsp_q   <= 16'hFFFF;
            rsp_err <= 2'b10;
            state   <= RESP;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        RESP: begin
          rsp_valid <= ONE << sel;
          rr_ptr    <= (sel == PW'(NREQ - 1)) ? '0 : sel + 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_16_arbiter.sv
// Directed bench for div_16_arbiter with a behavioural 17-cycle divider stand-in.
module tb_div_16_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] a_in, b_in;
  logic [3:0]  gnt, rsp_valid;
  logic [15:0] rsp_q, div_a, div_b, div_r;
  logic [1:0]  rsp_err;
  logic        busy, div_init, div_done;
  logic        hang;
  logic [4:0]  dcnt;
  logic [15:0] dq;
  int          n_chk = 0;
  int          n_err = 0;
  int          lat;

  always #5 clk = ~clk;

  div_16_arbiter #(.NREQ(4), .INIT_CYCLES(2), .TIMEOUT(40)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_q(rsp_q), .rsp_err(rsp_err),
    .busy(busy), .div_init(div_init), .div_a(div_a), .div_b(div_b),
    .div_r(div_r), .div_done(div_done)
  );

  // Divider stand-in: latches operands while init is high, done 17 cycles after init falls
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      div_done <= 1'b0;
      div_r    <= '0;
      dcnt     <= '0;
      dq       <= '0;
    end else if (div_init) begin
      div_done <= 1'b0;
      dcnt     <= 5'd17;
      dq       <= (div_b != 0) ? div_a / div_b : 16'hFFFF;
    end else if (dcnt != 0) begin
      dcnt <= dcnt - 1'b1;
      if (dcnt == 5'd1 && !hang) begin
        div_done <= 1'b1;
        div_r    <= dq;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    a_in[16*i +: 16] = a;
    b_in[16*i +: 16] = b;
  endtask

  task automatic do_op(input string tag, input int idx, input logic [15:0] eq,
                       input logic [1:0] ee, input int einit, input logic [3:0] clr,
                       output int l);
    bit got;
    int ninit;
    got = 0;
    l   = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (gnt != 0) begin got = 1; break; end
    end
    chk({tag, "_gnt"}, 32'(gnt), 32'(1) << idx);
    if (!got) return;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    req   = req & ~clr;
    ninit = 0;
    got   = 0;
    for (int k = 0; k < 200; k++) begin
      if (rsp_valid != 0) begin got = 1; break; end
      ninit += int'(div_init);
      @(negedge clk);
      l++;
    end
    chk({tag, "_vld"}, 32'(rsp_valid), 32'(1) << idx);
    chk({tag, "_q"}, 32'(rsp_q), 32'(eq));
    chk({tag, "_err"}, 32'(rsp_err), 32'(ee));
    chk({tag, "_init"}, 32'(ninit), 32'(einit));
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1);
  end

  initial begin
    int npulse;
    bit got;
    rst = 1'b1; req = '0; a_in = '0; b_in = '0; hang = 1'b0;
    #1;
    chk("rst_gnt",  32'(gnt), 0);
    chk("rst_vld",  32'(rsp_valid), 0);
    chk("rst_q",    32'(rsp_q), 0);
    chk("rst_err",  32'(rsp_err), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_init", 32'(div_init), 0);
    chk("rst_a",    32'(div_a), 0);
    chk("rst_b",    32'(div_b), 0);
    @(negedge clk); rst = 1'b0;

    // single op: 0x52 / 9 = 9
    set_op(0, 16'h0052, 16'h0009);
    req = 4'b0001;
    do_op("single", 0, 16'h0009, 2'b00, 2, 4'b0001, lat);

    // divide-by-zero on requester 2: response the cycle after grant
    set_op(2, 16'h1234, 16'h0000);
    req = 4'b0100;
    do_op("dz", 2, 16'hFFFF, 2'b01, 0, 4'b0100, lat);
    chk("dz_lat", 32'(lat), 1);

    // reset to bring rr_ptr back to 0 for the round-robin sweep
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    set_op(0, 16'd100, 16'd7);
    set_op(1, 16'd255, 16'd5);
    set_op(2, 16'd16,  16'd4);
    set_op(3, 16'd9,   16'd3);
    req = 4'b1111;
    do_op("rr0", 0, 16'd14, 2'b00, 2, 4'b0000, lat);
    do_op("rr1", 1, 16'd51, 2'b00, 2, 4'b0000, lat);
    do_op("rr2", 2, 16'd4,  2'b00, 2, 4'b0000, lat);
    do_op("rr3", 3, 16'd3,  2'b00, 2, 4'b0000, lat);
    do_op("rr4", 0, 16'd14, 2'b00, 2, 4'b1111, lat);

    // fairness: grant 1 leaves rr_ptr=2, so with 1 and 3 pending, 3 goes first
    set_op(1, 16'd1000,  16'd10);
    set_op(3, 16'd50000, 16'd7);
    req = 4'b0010;
    do_op("pre1", 1, 16'd100, 2'b00, 2, 4'b0010, lat);
    req = 4'b1010;
    do_op("fair3", 3, 16'd7142, 2'b00, 2, 4'b1000, lat);
    do_op("fair1", 1, 16'd100,  2'b00, 2, 4'b0010, lat);

    // watchdog: divider never finishes
    hang = 1'b1;
    set_op(0, 16'h0052, 16'h0009);
    req = 4'b0001;
    do_op("tmo", 0, 16'hFFFF, 2'b10, 2, 4'b0001, lat);
    chk("tmo_lat", 32'(lat >= 42), 1);
    hang = 1'b0;
    req = 4'b0010;
    do_op("post_tmo", 1, 16'd100, 2'b00, 2, 4'b0010, lat);

    // asynchronous reset in the middle of WAIT
    req = 4'b0001;
    got = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (gnt != 0) begin got = 1; break; end
    end
    chk("mid_gnt", 32'(got), 1);
    req = '0;
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_busy", 32'(busy), 0);
    chk("mid_init", 32'(div_init), 0);
    chk("mid_a",    32'(div_a), 0);
    chk("mid_b",    32'(div_b), 0);
    chk("mid_vld",  32'(rsp_valid), 0);
    @(negedge clk); rst = 1'b0;
    npulse = 0;
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid != 0) npulse++;
    end
    chk("mid_norsp", 32'(npulse), 0);
    req = 4'b0001;
    do_op("post_rst", 0, 16'h0009, 2'b00, 2, 4'b0001, lat);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
